apb_protocol_monitor: RTL
=========================

# apb_protocol_monitor

Synthesizable, passive APB3/APB4 protocol monitor: the parametrised successor of our bus-interface assertion checks, generalised to N slave selects, configurable address/data width, APB4 PSTRB, and a PREADY timeout. It taps the bus between the APB master and its slaves. It tracks every transfer with a state machine, flags six protocol violations as pulses and sticky bits, and keeps saturating transfer, error and wait-state statistics for software or the bench scoreboard. It never drives the bus.

## Interface
Parameters:
- ADDR_W, 32, PADDR width
- DATA_W, 32, PWDATA width; must be 8, 16 or 32
- NUM_SLV, 4, number of PSEL lines (1..16)
- TIMEOUT, 16, maximum PREADY-low ACCESS cycles before a timeout flag; 0 disables the check
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  bus clock; all sampling on posedge
- rst  in  1  reset, asynchronous, active-high
- psel  in  NUM_SLV  slave selects
- penable  in  1  enable
- pwrite  in  1  direction
- paddr  in  ADDR_W  address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  write strobes
- pready  in  1  slave ready
- pslverr  in  1  slave error
- clr  in  1  synchronous clear of err_sticky and all counters
- err_mask  in  6  per-check interrupt enable
- err_pulse  out  6  one-cycle violation flags
- err_sticky  out  6  latched violation flags
- irq  out  1  |(err_sticky & err_mask)
- xfer_cnt  out  CNT_W  completed transfers
- slverr_cnt  out  CNT_W  completions with pslverr=1
- err_cnt  out  CNT_W  cycles with any err_pulse bit set
- max_wait  out  CNT_W  longest wait-state run seen

## Operation
- Check index: 0 SEL_MULTI, 1 NO_SETUP, 2 UNSTABLE, 3 TIMEOUT, 4 EARLY_DROP, 5 STRB_READ.
- FSM has states IDLE, SETUP and ACCESS. It is evaluated on the values sampled at each posedge.
- IDLE:
  - psel≠0 and penable=0 → SETUP. Capture paddr, pwrite, pwdata, pstrb and psel.
  - psel≠0 and penable=1 → flag NO_SETUP, capture the signals, → ACCESS.
  - Otherwise stay in IDLE.
- SETUP:
  - penable=1 and psel unchanged → ACCESS.
  - Any other case → flag NO_SETUP. If psel≠0, re-capture and stay in SETUP; otherwise → IDLE.
- ACCESS, every cycle: compare the current bus against the captures. paddr, pwrite and psel are always compared; pwdata and pstrb are compared only if the captured pwrite=1. A mismatch flags UNSTABLE.
- ACCESS, pready=1 → completion, then IDLE:
  - xfer_cnt increments; slverr_cnt increments if pslverr=1.
  - max_wait ← max(max_wait, wait_cnt).
  - wait_cnt clears.
- ACCESS, pready=0:
  - penable=0 or psel=0 → flag EARLY_DROP, → IDLE.
  - Otherwise wait_cnt increments, saturating. If wait_cnt reaches TIMEOUT, flag TIMEOUT once per transfer and stay in ACCESS.
- Checks in every state:
  - SEL_MULTI when popcount(psel)>1.
  - STRB_READ when psel≠0, pwrite=0 and pstrb≠0.
- err_sticky[i] sets on err_pulse[i] and clears on clr. If both occur in the same cycle, set wins.
- All counters saturate at 2^CNT_W−1. clr zeroes the counters; an increment in the same cycle as clr is dropped.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE.
- An asynchronous reset mid-transfer aborts tracking. The first cycle after release is evaluated as IDLE.
- Flag latency: err_pulse is registered and is high for exactly the cycle after the offending sample edge.
- irq is combinational from err_sticky, so it rises in the same cycle as err_sticky.
- Statistics update one cycle after the completing edge.
- Back-to-back transfers (completion followed directly by SETUP) are legal. Completion followed by penable still high is NO_SETUP.
- Several checks may fire in the same cycle; err_cnt increments by 1 only.

## Structure
- Package apb_mon_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - the check-index localparams and NUM_CHK=6.
- Sub-module apb_mon_sat_cnt: a CNT_W saturating counter with inc and clr inputs. Instantiate it for xfer_cnt, slverr_cnt and err_cnt.

## Test plan
- Legal write to slave 2 (paddr=0x10, 1 wait state), then a legal read → xfer_cnt=2, max_wait=1, err_pulse stays 0.
- penable high in the same cycle that psel=0x1 rises → err_pulse[1] is a single pulse, err_sticky[1]=1, irq=1 with err_mask=0x02.
- paddr changes from 0x10 to 0x14 during ACCESS while pready=0 → err_pulse[2].
- TIMEOUT=4 with pready held low for 10 cycles → err_pulse[3] pulses once on the 4th wait cycle; completion gives max_wait=10.
- psel=0x3 → err_pulse[0]. Read with pstrb=0xF → err_pulse[5]. Both in one cycle → err_cnt increments by 1.
- clr asserted in the same cycle as a new violation → that bit stays set in err_sticky and the counters read 0. Assert rst mid-ACCESS → all outputs 0, next transfer tracked cleanly.

Source files
------------

// File: rtl/apb_mon_pkg.sv
// Shared types and check indices for the APB protocol monitor.
package apb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int NUM_CHK        = 6;
  localparam int CHK_SEL_MULTI  = 0;
  localparam int CHK_NO_SETUP   = 1;
  localparam int CHK_UNSTABLE   = 2;
  localparam int CHK_TIMEOUT    = 3;
  localparam int CHK_EARLY_DROP = 4;
  localparam int CHK_STRB_READ  = 5;

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear drops a same-cycle increment.
module apb_mon_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 monitor: tracks each transfer, flags protocol violations and
// keeps saturating statistics. The first penable sample after SETUP is the first ACCESS cycle.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SLV-1:0]  psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic                pslverr,
  input  logic                clr,
  input  logic [NUM_CHK-1:0]  err_mask,
  output logic [NUM_CHK-1:0]  err_pulse,
  output logic [NUM_CHK-1:0]  err_sticky,
  output logic                irq,
  output logic [CNT_W-1:0]    xfer_cnt,
  output logic [CNT_W-1:0]    slverr_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    max_wait
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  apb_state_e state, state_next;

  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_write;
  logic [DATA_W-1:0]  cap_wdata;
  logic [STRB_W-1:0]  cap_strb;
  logic [NUM_SLV-1:0] cap_sel;
  logic [CNT_W-1:0]   wait_cnt, wait_next;
  logic               to_done, to_done_next;
  logic               capture, done, sel_any, access_now;
  logic [NUM_CHK-1:0] viol;

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    done         = 1'b0;
    viol         = '0;
    wait_next    = '0;
    to_done_next = 1'b0;
    sel_any      = |psel;
    access_now   = (state == ACCESS) || ((state == SETUP) && penable && (psel == cap_sel));

    case (state)
      IDLE: begin
        if (sel_any) begin
          capture = 1'b1;
          if (penable) begin
            viol[CHK_NO_SETUP] = 1'b1;
            state_next         = ACCESS;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        if (!access_now) begin
          viol[CHK_NO_SETUP] = 1'b1;
          if (sel_any) begin
            capture    = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: ;
    endcase

    if (access_now) begin
      if ((paddr != cap_addr) || (pwrite != cap_write) || (psel != cap_sel) ||
          (cap_write && ((pwdata != cap_wdata) || (pstrb != cap_strb))))
        viol[CHK_UNSTABLE] = 1'b1;
      if (pready) begin
        done       = 1'b1;
        state_next = IDLE;
      end else if (!penable || !sel_any) begin
        viol[CHK_EARLY_DROP] = 1'b1;
        state_next           = IDLE;
      end else begin
        state_next   = ACCESS;
        wait_next    = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
        to_done_next = to_done;
        // Timeout fires once per transfer; the done flag holds it off until the transfer ends.
        if ((TIMEOUT != 0) && (wait_next == TO_LIM) && !to_done) begin
          viol[CHK_TIMEOUT] = 1'b1;
          to_done_next      = 1'b1;
        end
      end
    end

    if ($countones(psel) > 1) viol[CHK_SEL_MULTI] = 1'b1;
    if (sel_any && !pwrite && (pstrb != '0)) viol[CHK_STRB_READ] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_strb   <= '0;
      cap_sel    <= '0;
      wait_cnt   <= '0;
      to_done    <= 1'b0;
      err_pulse  <= '0;
      err_sticky <= '0;
      max_wait   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      to_done   <= to_done_next;
      err_pulse <= viol;
      if (capture) begin
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
        cap_sel   <= psel;
      end
      // A new violation wins over a simultaneous clear.
      err_sticky <= (clr ? '0 : err_sticky) | viol;
      if (clr) max_wait <= '0;
      else if (done && (wait_cnt > max_wait)) max_wait <= wait_cnt;
    end
  end

  assign irq = |(err_sticky & err_mask);

  apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
    .clk(clk), .rst(rst), .inc(done), .clr(clr), .cnt(xfer_cnt)
  );

  apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_slverr_cnt (
    .clk(clk), .rst(rst), .inc(done && pslverr), .clr(clr), .cnt(slverr_cnt)
  );

  apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(|viol), .clr(clr), .cnt(err_cnt)
  );

endmodule
